// File: rtl/crc8_tx_appender.sv
`default_nettype none
// ============================================================================
// Module      : crc8_tx_appender
// Description : Byte-stream framer that forwards payload bytes and appends a
//               reflected CRC8 byte after the last payload byte of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module crc8_tx_appender #(
  parameter logic [7:0] CRC_INIT = 8'h0D,
  parameter logic [7:0] CRC_POLY = 8'hC6,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [7:0]       i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [7:0]       o_data,
  output logic             o_last,
  output logic [7:0]       o_crc8,
  output logic             o_done,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frame_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_PAYLOAD = 1'b0,
    ST_APPEND  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_crc;
  logic       r_frame_open;
  logic       w_slot_free;
  logic       w_accept;
  logic       w_load_crc;
  logic       w_crc_taken;

  // Reflected CRC: data bits enter LSB first, all eight in one cycle.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in;
    for (int j = 0; j < 8; j++) begin
      if (c[0] != data[j]) c = (c >> 1) ^ CRC_POLY;
      else                 c = c >> 1;
    end
    return c;
  endfunction

  assign w_slot_free = !o_valid || o_ready;
  assign i_ready     = !reset && (r_state == ST_PAYLOAD) && w_slot_free;
  assign w_accept    = i_valid && i_ready;
  assign w_load_crc  = (r_state == ST_APPEND) && w_slot_free;
  assign w_crc_taken = o_valid && o_ready && o_last;
  assign o_busy      = (r_state == ST_APPEND) || o_valid || r_frame_open;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_PAYLOAD;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PAYLOAD: if (w_accept && i_last) w_state_next = ST_APPEND;
      ST_APPEND:  if (w_slot_free)        w_state_next = ST_PAYLOAD;
      default:                            w_state_next = ST_PAYLOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc        <= CRC_INIT;
      r_frame_open <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= 8'h00;
      o_last       <= 1'b0;
      o_crc8       <= 8'h00;
      o_done       <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      if (w_accept) begin
        o_data       <= i_data;
        o_last       <= 1'b0;
        o_valid      <= 1'b1;
        r_crc        <= crc8_update(r_crc, i_data);
        r_frame_open <= 1'b1;
      end else if (w_load_crc) begin
        o_data       <= r_crc;
        o_last       <= 1'b1;
        o_valid      <= 1'b1;
        o_crc8       <= r_crc;
        r_crc        <= CRC_INIT;
        r_frame_open <= 1'b0;
      end else if (w_slot_free) begin
        o_valid <= 1'b0;
      end
      // Frame completion is counted when the CRC byte leaves, not when it is loaded.
      o_done <= w_crc_taken;
      if (w_crc_taken) o_frame_cnt <= o_frame_cnt + c_CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: doc/crc8_tx_appender.md
Name: crc8_tx_appender

Overview:
Transmit-side CRC8 framer for the Sigma Delta DAQ byte link. It forwards payload bytes from an upstream byte stream and appends one CRC8 byte after the last payload byte. A downstream CRC8 checker, using the same init, polynomial and bit order, therefore ends each frame with a residue of 0x00. The block sits between the packet builder and the serializer, with valid/ready handshakes on both sides.

Parameters:
CRC_INIT, 8'h0D, CRC register start value for every frame
CRC_POLY, 8'hC6, reflected polynomial XORed after each right shift
CNT_W, 16, width of the frame counter

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
i_valid  in  1  upstream byte valid
i_ready  out  1  block accepts the upstream byte this cycle
i_data  in  8  payload byte
i_last  in  1  marks the final payload byte of the frame; qualified by i_valid
o_valid  out  1  downstream byte valid
o_ready  in  1  downstream accepts the byte
o_data  out  8  payload byte or appended CRC byte
o_last  out  1  high only on the appended CRC byte
o_crc8  out  8  CRC of the most recently completed frame
o_done  out  1  one-cycle pulse when the CRC byte handshakes downstream
o_busy  out  1  high while a frame is in progress or the output register holds data
o_frame_cnt  out  CNT_W  number of frames fully sent; wraps modulo 2^CNT_W

Behaviour:
- Reset values: state=PAYLOAD, crc=CRC_INIT, o_valid=0, o_data=0, o_last=0, o_crc8=0, o_done=0, o_frame_cnt=0. Derived outputs: i_ready=0 while reset is asserted, o_busy=0.
- Reset mid-frame drops the partial frame. Nothing already emitted is retracted, and no CRC byte is sent.
- Per-byte CRC update, applied bit 0 first through bit 7: if crc[0] != data[j] then crc=(crc>>1)^CRC_POLY, else crc=crc>>1. All 8 bits complete in one cycle.
- Output stage is a single register. slot_free = !o_valid || o_ready.
- States:
  - PAYLOAD: i_ready = slot_free. On i_valid && i_ready: o_data<=i_data, o_last<=0, o_valid<=1, crc<=update(crc,i_data). If i_last is also high, go to APPEND.
  - APPEND: i_ready=0. When slot_free: o_data<=crc, o_last<=1, o_valid<=1, o_crc8<=crc, crc<=CRC_INIT, go to PAYLOAD.
  - When slot_free holds but no new byte is loaded, o_valid<=0.
- Stall: while o_valid && !o_ready, o_data and o_last hold stable and i_ready=0.
- Latency: an accepted byte appears on o_data the next cycle. With o_ready held high, the CRC byte follows the last payload byte in the next cycle.
- Throughput: one idle input cycle per frame, the APPEND cycle.
- o_done=1 for exactly the cycle after o_valid && o_ready && o_last. In that same cycle o_frame_cnt increments; at all-ones it wraps to 0.
- o_busy = (state==APPEND) || o_valid || (crc != CRC_INIT, tracked by a frame-open flag set on the first accepted byte).
- Single-byte frames (i_last on the first byte) are legal. Zero-length frames do not exist, because i_last is only sampled together with a byte.
- A new frame's first byte can be accepted in the same cycle the previous CRC byte is consumed.
- i_last while i_valid=0 is ignored.

Test Plan:
- Single byte {0x00} with i_last, o_ready=1 -> o_data 0x00 (o_last=0), then 0xC7 (o_last=1); o_crc8=0xC7, o_done pulses once, o_frame_cnt=1.
- Two bytes {0x00,0x00} -> output 0x00,0x00,0xDC, with o_last only on 0xDC. Feeding the three output bytes through the checker algorithm from 0x0D gives 0x00.
- Random frames of 1-64 bytes with random o_ready backpressure -> o_data/o_last are stable while stalled, no bytes are lost or duplicated, each CRC matches the reference model, and checker residue is 0x00 every frame.
- Back-to-back frames with i_valid held high and o_ready=1 -> exactly one i_ready=0 cycle per frame. The CRC register restarts at 0x0D, e.g. a second {0x00} frame gives 0xC7 again.
- Reset asserted after 3 of 5 payload bytes -> o_valid=0 the next cycle, no CRC byte, o_frame_cnt unchanged. The next frame {0x00} still yields 0xC7.
- Force o_frame_cnt to 0xFFFF (CNT_W=16) and complete one frame -> it wraps to 0x0000 while o_done pulses.
